// File: rtl/serial_signed_sub_with_saturation.sv
// Bit-serial signed subtractor (a - b), LSB first, one bit per clock,
// with saturation to the W-bit two's-complement range and valid/ready handshakes.
module serial_signed_sub_with_saturation #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         saturated
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-2:0]   res;
    logic [CW-1:0]  cnt;
    logic           carry;

    logic           accept;
    logic           last;
    logic           sum_bit;
    logic           carry_next;
    logic           ovf;
    logic [W-1:0]   raw;
    logic [W-1:0]   sat_val;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake decode; in_ready/out_valid depend on state only
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        last       = (cnt == CW'(W - 1));
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One full-adder slice of a + ~b + 1; on the last bit a_sh[0]/b_sh[0] are the sign bits
    always_comb begin
        sum_bit    = a_sh[0] ^ ~b_sh[0] ^ carry;
        carry_next = (a_sh[0] & ~b_sh[0]) | (a_sh[0] & carry) | (~b_sh[0] & carry);
        raw        = {sum_bit, res};
        ovf        = (a_sh[0] != b_sh[0]) && (sum_bit != a_sh[0]);
        sat_val    = a_sh[0] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end

    // Operand shift registers, result accumulation and output load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            diff      <= '0;
            saturated <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            cnt   <= '0;
            carry <= 1'b1;
        end else if (state == SHIFT) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res   <= raw[W-1:1];
            carry <= carry_next;
            cnt   <= cnt + CW'(1);
            if (last) begin
                diff      <= ovf ? sat_val : raw;
                saturated <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_serial_signed_sub_with_saturation.sv
// Self-checking bench: directed table, timing/backpressure/reset sequences,
// and scoreboard-checked random streams on W=4 and W=8 instances.
module tb_serial_signed_sub_with_saturation;

    logic       clk;
    logic       rst_n;
    logic       iv4, ir4, ov4, or4, s4;
    logic [3:0] a4, b4, d4;
    logic       iv8, ir8, ov8, or8, s8;
    logic [7:0] a8, b8, d8;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       sat;
        logic [7:0] diff;
    } exp_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] diff;
        logic       sat;
    } vec_t;

    exp_t q4[$];
    exp_t q8[$];

    serial_signed_sub_with_saturation #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(or4), .diff(d4), .saturated(s4)
    );

    serial_signed_sub_with_saturation #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .diff(d8), .saturated(s8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout/unexpected want handshake", name);
    endtask

    function automatic exp_t ref_sub(input int w, input logic [7:0] a, input logic [7:0] b);
        int   av, bv, d, mx, mn;
        exp_t r;
        av = int'(a);
        bv = int'(b);
        if (av >= (1 << (w - 1))) av = av - (1 << w);
        if (bv >= (1 << (w - 1))) bv = bv - (1 << w);
        d  = av - bv;
        mx = (1 << (w - 1)) - 1;
        mn = -(1 << (w - 1));
        r.sat = (d > mx) || (d < mn);
        if (d > mx) d = mx;
        else if (d < mn) d = mn;
        r.diff = 8'(d & ((1 << w) - 1));
        return r;
    endfunction

    // Scoreboard: push model result on accept, pop and compare on result handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q4.delete();
            q8.delete();
        end else begin
            if (iv4 && ir4) q4.push_back(ref_sub(4, {4'b0, a4}, {4'b0, b4}));
            if (ov4 && or4) begin
                if (q4.size() == 0) fail("sb4_orphan");
                else begin
                    e = q4.pop_front();
                    check("sb4", 32'({s4, d4}), 32'({e.sat, e.diff[3:0]}));
                end
            end
            if (iv8 && ir8) q8.push_back(ref_sub(8, a8, b8));
            if (ov8 && or8) begin
                if (q8.size() == 0) fail("sb8_orphan");
                else begin
                    e = q8.pop_front();
                    check("sb8", 32'({s8, d8}), 32'({e.sat, e.diff}));
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_r4;
        tick();
        or4 = 1'($urandom_range(0, 1));
    endtask

    task automatic tick_r8;
        tick();
        or8 = 1'($urandom_range(0, 1));
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] d, output logic s);
        int n;
        a4 = a; b4 = b; iv4 = 1'b1; or4 = 1'b1;
        n = 0;
        while (!ir4 && n < 20) begin tick(); n++; end
        tick();
        iv4 = 1'b0;
        n = 0;
        while (!ov4 && n < 20) begin tick(); n++; end
        if (!ov4) fail("run4_timeout");
        d = d4;
        s = s4;
        tick();
    endtask

    initial begin
        vec_t       vecs[10];
        logic [3:0] d;
        logic       s;
        int         n;

        vecs[0] = '{4'd3,  4'd5,  4'b1110, 1'b0};
        vecs[1] = '{4'd7,  4'hF,  4'b0111, 1'b1};
        vecs[2] = '{4'd0,  4'h8,  4'b0111, 1'b1};
        vecs[3] = '{4'h8,  4'd1,  4'b1000, 1'b1};
        vecs[4] = '{4'h8,  4'h8,  4'b0000, 1'b0};
        vecs[5] = '{4'd2,  4'd1,  4'b0001, 1'b0};
        vecs[6] = '{4'hD,  4'd4,  4'b1001, 1'b0};
        vecs[7] = '{4'hF,  4'd1,  4'b1110, 1'b0};
        vecs[8] = '{4'd5,  4'hD,  4'b0111, 1'b1};
        vecs[9] = '{4'h9,  4'd7,  4'b1000, 1'b1};

        rst_n = 1'b0;
        iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
        #2;
        check("rst_ir", 32'(ir4), 32'(1));
        check("rst_ov", 32'(ov4), 32'(0));
        check("rst_out", 32'({s4, d4}), 32'(0));
        check("rst_ov8", 32'({ov8, s8, d8}), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Basic latency: 3 - 5
        a4 = 4'd3; b4 = 4'd5; iv4 = 1'b1; or4 = 1'b1;
        check("basic_ir_before", 32'(ir4), 32'(1));
        tick();
        iv4 = 1'b0;
        repeat (3) tick();
        check("basic_ov_early", 32'(ov4), 32'(0));
        tick();
        check("basic_ov", 32'(ov4), 32'(1));
        check("basic_ir_busy", 32'(ir4), 32'(0));
        check("basic_out", 32'({s4, d4}), 32'({1'b0, 4'b1110}));
        tick();
        check("basic_ir_after", 32'(ir4), 32'(1));
        check("basic_ov_after", 32'(ov4), 32'(0));
        check("basic_hold", 32'({s4, d4}), 32'({1'b0, 4'b1110}));

        for (int i = 0; i < 10; i++) begin
            run4(vecs[i].a, vecs[i].b, d, s);
            check($sformatf("vec%0d", i), 32'({s, d}), 32'({vecs[i].sat, vecs[i].diff}));
        end

        // Backpressure with an ignored in_valid during DONE
        or4 = 1'b0; a4 = 4'd2; b4 = 4'd1; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        repeat (4) tick();
        a4 = 4'd5; b4 = 4'd0; iv4 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_ov%0d", k), 32'(ov4), 32'(1));
            check($sformatf("bp_out%0d", k), 32'({s4, d4}), 32'({1'b0, 4'b0001}));
            check($sformatf("bp_ir%0d", k), 32'(ir4), 32'(0));
            tick();
        end
        or4 = 1'b1;
        tick();
        a4 = 4'd6; b4 = 4'd2;
        check("bp_ir_idle", 32'(ir4), 32'(1));
        tick();
        iv4 = 1'b0;
        n = 0;
        while (!ov4 && n < 20) begin tick(); n++; end
        check("bp_next", 32'({ov4, s4, d4}), 32'({1'b1, 1'b0, 4'b0100}));
        tick();

        // Reset during the second SHIFT cycle
        a4 = 4'd7; b4 = 4'hF; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", 32'(ov4), 32'(0));
        check("mid_rst_out", 32'({s4, d4}), 32'(0));
        check("mid_rst_ir", 32'(ir4), 32'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        run4(4'hD, 4'd4, d, s);
        check("post_rst", 32'({s, d}), 32'({1'b0, 4'b1001}));

        // W=4 exhaustive with random stalls
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                repeat ($urandom_range(0, 2)) tick_r4();
                a4 = 4'(a); b4 = 4'(b); iv4 = 1'b1;
                n = 0;
                while (!ir4 && n < 100) begin tick_r4(); n++; end
                if (!ir4) fail("rnd4_timeout");
                tick_r4();
                iv4 = 1'b0;
            end
        end
        or4 = 1'b1;
        n = 0;
        while ((q4.size() != 0 || !ir4) && n < 50) begin tick(); n++; end
        check("drain4", 32'(q4.size()), 32'(0));

        // W=8 random pairs with random stalls
        for (int i = 0; i < 2000; i++) begin
            repeat ($urandom_range(0, 1)) tick_r8();
            a8 = 8'($urandom); b8 = 8'($urandom); iv8 = 1'b1;
            n = 0;
            while (!ir8 && n < 100) begin tick_r8(); n++; end
            if (!ir8) fail("rnd8_timeout");
            tick_r8();
            iv8 = 1'b0;
        end
        or8 = 1'b1;
        n = 0;
        while ((q8.size() != 0 || !ir8) && n < 50) begin tick(); n++; end
        check("drain8", 32'(q8.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
